operand_stack: RTL and testbench

//  Parametrised WebAssembly operand (value) stack for the cpu core.

---
 rtl/operand_stack.sv | 154 +++++++++++++++
 tb/tb_operand_stack.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/operand_stack.sv
// rtl/operand_stack.sv - WebAssembly operand stack with registered top/next and sticky trap
// Top two entries live in registers; deeper entries spill into a small RAM indexed by count-3.
module operand_stack #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [2:0]                 op,
  input  logic [WIDTH-1:0]           data_in,
  output logic [WIDTH-1:0]           top,
  output logic [WIDTH-1:0]           next,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full,
  output logic                       top_eqz,
  output logic [2:0]                 trap
);

  localparam int CW        = $clog2(DEPTH + 1);
  localparam int RAM_DEPTH = (DEPTH > 2) ? (DEPTH - 2) : 1;
  localparam int AW        = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [2:0] {
    OP_NOP     = 3'd0,
    OP_PUSH    = 3'd1,
    OP_POP     = 3'd2,
    OP_REPLACE = 3'd3,
    OP_BINOP   = 3'd4,
    OP_POP2    = 3'd5,
    OP_DUP     = 3'd6,
    OP_RSVD    = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    TRAP_NONE      = 3'd0,
    TRAP_UNDERFLOW = 3'd1,
    TRAP_OVERFLOW  = 3'd2,
    TRAP_INVALID   = 3'd3
  } trap_e;

  logic [WIDTH-1:0] top_q, top_d;
  logic [WIDTH-1:0] next_q, next_d;
  logic [CW-1:0]    count_q, count_d;
  logic [2:0]       trap_q, trap_d;

  logic [WIDTH-1:0] ram_q [RAM_DEPTH];
  logic             ram_we;
  logic [AW-1:0]    ram_waddr;
  logic [AW-1:0]    rd1_addr, rd2_addr;
  logic [WIDTH-1:0] rd1, rd2;

  // rd1 is the entry just below next, rd2 the one below that.
  assign ram_waddr = AW'(count_q - CW'(2));
  assign rd1_addr  = AW'(count_q - CW'(3));
  assign rd2_addr  = AW'(count_q - CW'(4));
  assign rd1       = (count_q >= CW'(3)) ? ram_q[rd1_addr] : '0;
  assign rd2       = (count_q >= CW'(4)) ? ram_q[rd2_addr] : '0;

  always_comb begin
    top_d   = top_q;
    next_d  = next_q;
    count_d = count_q;
    trap_d  = trap_q;
    ram_we  = 1'b0;
    if (trap_q == TRAP_NONE) begin
      case (op)
        OP_NOP: ;
        OP_PUSH: begin
          if (count_q == DEPTH_C) begin
            trap_d = TRAP_OVERFLOW;
          end else begin
            next_d  = top_q;
            top_d   = data_in;
            count_d = count_q + CW'(1);
            ram_we  = (count_q >= CW'(2));
          end
        end
        OP_POP: begin
          if (count_q == '0) begin
            trap_d = TRAP_UNDERFLOW;
          end else begin
            top_d   = next_q;
            next_d  = rd1;
            count_d = count_q - CW'(1);
          end
        end
        OP_REPLACE: begin
          if (count_q == '0) trap_d = TRAP_UNDERFLOW;
          else               top_d  = data_in;
        end
        OP_BINOP: begin
          if (count_q < CW'(2)) begin
            trap_d = TRAP_UNDERFLOW;
          end else begin
            top_d   = data_in;
            next_d  = rd1;
            count_d = count_q - CW'(1);
          end
        end
        OP_POP2: begin
          if (count_q < CW'(2)) begin
            trap_d = TRAP_UNDERFLOW;
          end else begin
            top_d   = rd1;
            next_d  = rd2;
            count_d = count_q - CW'(2);
          end
        end
        OP_DUP: begin
          if (count_q == '0) begin
            trap_d = TRAP_UNDERFLOW;
          end else if (count_q == DEPTH_C) begin
            trap_d = TRAP_OVERFLOW;
          end else begin
            next_d  = top_q;
            count_d = count_q + CW'(1);
            ram_we  = (count_q >= CW'(2));
          end
        end
        default: trap_d = TRAP_INVALID;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      top_q   <= '0;
      next_q  <= '0;
      count_q <= '0;
      trap_q  <= TRAP_NONE;
    end else begin
      top_q   <= top_d;
      next_q  <= next_d;
      count_q <= count_d;
      trap_q  <= trap_d;
    end
  end

  // Storage is deliberately left uncleared by reset; count gates every read.
  always_ff @(posedge clk) begin
    if (ram_we && !reset) ram_q[ram_waddr] <= next_q;
  end

  assign top     = top_q;
  assign next    = next_q;
  assign count   = count_q;
  assign empty   = (count_q == '0);
  assign full    = (count_q == DEPTH_C);
  assign top_eqz = (count_q != '0) && (top_q == '0);
  assign trap    = trap_q;

endmodule

// File: tb/tb_operand_stack.sv
// tb/tb_operand_stack.sv - scoreboard bench for operand_stack (WIDTH=64, DEPTH=4)
module tb_operand_stack;

  localparam int WIDTH = 64;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [2:0]       op = 3'd0;
  logic [WIDTH-1:0] data_in = '0;
  logic [WIDTH-1:0] top, next;
  logic [2:0]       count;
  logic             empty, full, top_eqz;
  logic [2:0]       trap;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [WIDTH-1:0] top;
    logic [WIDTH-1:0] next;
    logic [2:0]       count;
    logic             empty;
    logic             full;
    logic             eqz;
    logic [2:0]       trap;
  } exp_t;

  exp_t             sb[$];
  logic [WIDTH-1:0] mstk[$];
  logic [2:0]       mtrap = 3'd0;

  operand_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .op(op), .data_in(data_in),
    .top(top), .next(next), .count(count), .empty(empty),
    .full(full), .top_eqz(top_eqz), .trap(trap)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_expected();
    exp_t e;
    int n = mstk.size();
    e.top   = (n >= 1) ? mstk[n-1] : '0;
    e.next  = (n >= 2) ? mstk[n-2] : '0;
    e.count = 3'(n);
    e.empty = (n == 0);
    e.full  = (n == DEPTH);
    e.eqz   = (n >= 1) && (mstk[n-1] == '0);
    e.trap  = mtrap;
    sb.push_back(e);
  endtask

  task automatic compare_state(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 64'd1, 64'd0);
      return;
    end
    e = sb.pop_front();
    check({tag, "_top"},   top,            e.top);
    check({tag, "_next"},  next,           e.next);
    check({tag, "_count"}, 64'(count),     64'(e.count));
    check({tag, "_flags"}, 64'({empty, full, top_eqz}), 64'({e.empty, e.full, e.eqz}));
    check({tag, "_trap"},  64'(trap),      64'(e.trap));
  endtask

  task automatic model_op(input logic [2:0] o, input logic [WIDTH-1:0] d);
    int n = mstk.size();
    if (mtrap != 3'd0) return;
    case (o)
      3'd0: ;
      3'd1: if (n == DEPTH) mtrap = 3'd2; else mstk.push_back(d);
      3'd2: if (n == 0) mtrap = 3'd1; else void'(mstk.pop_back());
      3'd3: if (n == 0) mtrap = 3'd1; else mstk[n-1] = d;
      3'd4: if (n < 2) mtrap = 3'd1;
            else begin void'(mstk.pop_back()); void'(mstk.pop_back()); mstk.push_back(d); end
      3'd5: if (n < 2) mtrap = 3'd1;
            else begin void'(mstk.pop_back()); void'(mstk.pop_back()); end
      3'd6: if (n == 0) mtrap = 3'd1;
            else if (n == DEPTH) mtrap = 3'd2;
            else mstk.push_back(mstk[n-1]);
      default: mtrap = 3'd3;
    endcase
  endtask

  task automatic do_op(input string tag, input logic [2:0] o, input logic [WIDTH-1:0] d);
    op = o;
    data_in = d;
    model_op(o, d);
    push_expected();
    @(posedge clk);
    #1;
    compare_state(tag);
  endtask

  // Asserted between edges so the asynchronous clear is visible before any clock.
  task automatic do_reset(input string tag);
    #2;
    reset = 1'b1;
    op = 3'd0;
    #1;
    mstk.delete();
    mtrap = 3'd0;
    push_expected();
    compare_state(tag);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    @(posedge clk);
    #1;
    do_reset("t1_reset");
    do_op("t1_nop0", 3'd0, 64'd0);
    do_op("t1_nop1", 3'd0, 64'd0);
    do_op("t1_nop2", 3'd0, 64'd0);

    do_op("t2_push5", 3'd1, 64'd5);
    do_op("t2_push0", 3'd1, 64'd0);
    check("t2_eqz_hi", 64'(top_eqz), 64'd1);
    do_op("t2_binop", 3'd4, 64'd1);
    check("t2_binop_top", top, 64'd1);

    do_reset("t3_reset");
    do_op("t3_push1", 3'd1, 64'd1);
    do_op("t3_push2", 3'd1, 64'd2);
    do_op("t3_push3", 3'd1, 64'd3);
    do_op("t3_push4", 3'd1, 64'd4);
    check("t3_full", 64'(full), 64'd1);
    do_op("t3_push9", 3'd1, 64'd9);
    check("t3_ovf_trap", 64'(trap), 64'd2);
    check("t3_ovf_top", top, 64'd4);
    do_op("t3_pop_sticky", 3'd2, 64'd0);
    check("t3_sticky_count", 64'(count), 64'd4);

    do_reset("t4_reset");
    do_op("t4_pop_under", 3'd2, 64'd0);
    check("t4_under_trap", 64'(trap), 64'd1);
    do_reset("t4_async_reset");
    check("t4_async_trap", 64'(trap), 64'd0);

    do_op("t5_push10", 3'd1, 64'd10);
    do_op("t5_push20", 3'd1, 64'd20);
    do_op("t5_push30", 3'd1, 64'd30);
    do_op("t5_push40", 3'd1, 64'd40);
    do_op("t5_pop2", 3'd5, 64'd0);
    check("t5_pop2_top", top, 64'd20);
    check("t5_pop2_next", next, 64'd10);
    do_op("t5_pop_a", 3'd2, 64'd0);
    do_op("t5_pop_b", 3'd2, 64'd0);
    check("t5_empty", 64'(empty), 64'd1);

    do_reset("t6_reset");
    do_op("t6_push7", 3'd1, 64'd7);
    do_op("t6_dup", 3'd6, 64'd0);
    check("t6_dup_next", next, 64'd7);
    do_op("t6_replace", 3'd3, 64'd8);
    do_op("t6_dup2", 3'd6, 64'd0);
    do_op("t6_dup3", 3'd6, 64'd0);
    do_op("t6_dup_ovf", 3'd6, 64'd0);
    do_reset("t6_reset2");
    do_op("t6_push_a", 3'd1, 64'hdead_beef_0000_0001);
    do_op("t6_push_b", 3'd1, 64'h2);
    do_op("t6_push_c", 3'd1, 64'h3);
    do_op("t6_binop_refill", 3'd4, 64'h0);
    do_op("t6_pop2_low", 3'd5, 64'h0);
    do_op("t6_pop2_under", 3'd5, 64'h0);
    do_reset("t6_reset3");
    do_op("t6_push_d", 3'd1, 64'd3);
    do_op("t6_invalid", 3'd7, 64'd0);
    check("t6_invalid_trap", 64'(trap), 64'd3);
    do_op("t6_after_invalid", 3'd1, 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
